counter_seq_ctrl: RTL and testbench

//  Sequencer for the board's up-counter/hex-display datapath. Accepts START/STOP/CLEAR/LOAD

---
 rtl/counter_seq_pkg.sv | 19 +
 rtl/counter_seq_ctrl_tick_gen.sv | 42 ++++
 rtl/counter_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Purpose : shared opcodes and FSM state encoding for the counter sequencer.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package counter_seq_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/counter_seq_ctrl_tick_gen.sv
// Purpose : prescaler that divides the clock into one-cycle count ticks.
// Latency : tick_o is combinational from the prescaler register (asserted when it sits at DIV-1).
// Backpressure: none; hold_i/en_i freeze the prescaler, clr_i returns it to 0.
// Ports   : clock, Resetn (sync, active-low), clr_i, en_i, hold_i, tick_o.
module tick_gen #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clock,
  input  logic Resetn,
  input  logic clr_i,
  input  logic en_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  // clr wins over everything; hold freezes the value even while enabled
  always_comb begin
    pre_d  = pre_q;
    tick_o = 1'b0;
    if (clr_i) begin
      pre_d = '0;
    end else if (en_i && !hold_i) begin
      if (pre_q == LAST) begin
        pre_d  = '0;
        tick_o = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!Resetn) pre_q <= '0;
    else         pre_q <= pre_d;
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Purpose : command-driven sequencer for the up-counter / hex display datapath.
// Latency : command effect and tick-driven count updates appear one cycle after the edge.
// Backpressure: cmd_ready is registered and drops for exactly one cycle after each acceptance.
// Ports   : clock, Resetn (sync, active-low); cmd_valid/cmd_ready/cmd_op/cmd_data command
//           handshake; limit, oneshot control; count, running, tc_pulse status.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 50_000_000
) (
  input  logic             clock,
  input  logic             Resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] limit,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tc_pulse
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             rdy_q;

  logic accept;
  logic tick;
  logic pre_clr, pre_en, pre_hold;

  assign accept = cmd_valid & rdy_q;

  // Prescaler only runs in RUN. IDLE/DONE keep it at zero; a STOP freezes it
  // on the accepting cycle so a later START resumes from exactly where it was.
  assign pre_en   = (state_q == ST_RUN);
  assign pre_hold = accept && (cmd_op == OP_STOP);
  assign pre_clr  = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                    ((state_q == ST_RUN) && accept &&
                     ((cmd_op == OP_CLEAR) || (cmd_op == OP_LOAD)));

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clock  (clock),
    .Resetn (Resetn),
    .clr_i  (pre_clr),
    .en_i   (pre_en),
    .hold_i (pre_hold),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;

    if (accept) begin
      // An accepted command always overrides a coincident tick.
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_op == OP_START)      state_d = ST_RUN;
          else if (cmd_op == OP_CLEAR) count_d = '0;
          else if (cmd_op == OP_LOAD)  count_d = cmd_data;
        end
        ST_RUN: begin
          if (cmd_op == OP_STOP)       state_d = ST_PAUSE;
          else if (cmd_op == OP_CLEAR) count_d = '0;
          else if (cmd_op == OP_LOAD)  count_d = cmd_data;
        end
        ST_PAUSE: begin
          if (cmd_op == OP_START) begin
            state_d = ST_RUN;
          end else if (cmd_op == OP_CLEAR) begin
            state_d = ST_IDLE;
            count_d = '0;
          end else if (cmd_op == OP_LOAD) begin
            count_d = cmd_data;
          end
        end
        ST_DONE: begin
          if (cmd_op == OP_START) begin
            state_d = ST_RUN;
            count_d = '0;
          end else if (cmd_op == OP_CLEAR) begin
            state_d = ST_IDLE;
            count_d = '0;
          end else if (cmd_op == OP_LOAD) begin
            state_d = ST_IDLE;
            count_d = cmd_data;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tick) begin
      // Values above limit simply roll through all-ones to 0 and keep climbing.
      if (count_q != limit) begin
        count_d = count_q + WIDTH'(1);
      end else if (oneshot) begin
        tc_d    = 1'b1;
        state_d = ST_DONE;
      end else begin
        tc_d    = 1'b1;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      rdy_q   <= ~accept;
    end
  end

  assign cmd_ready = rdy_q;
  assign count     = count_q;
  assign running   = (state_q == ST_RUN);
  assign tc_pulse  = tc_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Purpose : self-checking bench for counter_seq_ctrl with DIV=4, WIDTH=16.
// Latency : expected count/tc events queued at stimulus time, compared as the DUT emits them.
// Backpressure: commands wait on cmd_ready with a bounded cycle budget.
module tb_counter_seq_ctrl;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  logic        clock = 1'b0;
  logic        Resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] limit;
  logic        oneshot;
  logic [15:0] count;
  logic        running;
  logic        tc_pulse;

  counter_seq_ctrl #(.WIDTH(16), .DIV(4)) dut (
    .clock     (clock),
    .Resetn    (Resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .limit     (limit),
    .oneshot   (oneshot),
    .count     (count),
    .running   (running),
    .tc_pulse  (tc_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] cnt;
    logic        tc;
    int          gap;   // cycles since previous event; 0 = don't care
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        mon_en   = 1'b0;
  logic [15:0] last_count = '0;
  int          cyc_since = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] c, input logic t, input int g);
    exp_t e;
    e.cnt = c;
    e.tc  = t;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  // Every count change or tc pulse is an output event matched against the queue.
  always @(negedge clock) begin
    exp_t e;
    cyc_since++;
    if (mon_en && ((count !== last_count) || (tc_pulse === 1'b1))) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_event", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_count", count, e.cnt);
        check_eq("sb_tc", tc_pulse, e.tc);
        if (e.gap != 0) check_eq("sb_gap", cyc_since, e.gap);
      end
      cyc_since = 0;
    end
    last_count = count;
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] data);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check_eq("send_ready_timeout", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_START;
    cmd_data  = '0;
    limit     = 16'd3;
    oneshot   = 1'b0;

    // Reset state
    repeat (2) step();
    check_eq("rst_count", count, 0);
    check_eq("rst_running", running, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_tc", tc_pulse, 0);
    Resetn = 1'b1;
    mon_en = 1'b1;

    // Free-run wrap: 1,2,3 every 4 cycles, then 0 with tc
    push(16'd1, 1'b0, 0);
    push(16'd2, 1'b0, 4);
    push(16'd3, 1'b0, 4);
    push(16'd0, 1'b1, 4);
    send(OP_START, '0);
    check_eq("wrap_running_start", running, 1);
    drain("wrap_drain", 40);
    check_eq("wrap_running_end", running, 1);
    send(OP_STOP, '0);
    check_eq("wrap_stop_running", running, 0);
    send(OP_CLEAR, '0);
    check_eq("wrap_clear_count", count, 0);

    // One-shot from a loaded value above limit
    limit   = 16'd2;
    oneshot = 1'b1;
    push(16'hFFFE, 1'b0, 0);
    send(OP_LOAD, 16'hFFFE);
    check_eq("os_load_count", count, 16'hFFFE);
    check_eq("os_load_running", running, 0);
    push(16'hFFFF, 1'b0, 0);
    push(16'h0000, 1'b0, 4);
    push(16'h0001, 1'b0, 4);
    push(16'h0002, 1'b0, 4);
    push(16'h0002, 1'b1, 4);
    send(OP_START, '0);
    drain("os_drain", 80);
    check_eq("os_done_running", running, 0);
    check_eq("os_done_tc", tc_pulse, 0);
    repeat (10) step();
    check_eq("os_done_hold", count, 2);

    // STOP at prescaler=2, pause, resume
    limit   = 16'd100;
    oneshot = 1'b0;
    push(16'd0, 1'b0, 0);
    push(16'd1, 1'b0, 4);
    send(OP_START, '0);
    for (int i = 0; i < 40; i++) begin
      if (count == 16'd1) break;
      step();
    end
    check_eq("pause_reach_one", count, 1);
    repeat (2) step();
    send(OP_STOP, '0);
    check_eq("pause_running", running, 0);
    repeat (20) step();
    check_eq("pause_hold", count, 1);
    push(16'd2, 1'b0, 0);
    send(OP_START, '0);
    check_eq("resume_running", running, 1);
    check_eq("resume_c1", count, 1);
    step();
    check_eq("resume_c2", count, 1);
    step();
    check_eq("resume_c3", count, 2);

    // CLEAR on the tick cycle
    repeat (3) step();
    push(16'd0, 1'b0, 0);
    push(16'd1, 1'b0, 4);
    send(OP_CLEAR, '0);
    check_eq("clr_tick_count", count, 0);
    check_eq("clr_tick_tc", tc_pulse, 0);
    check_eq("clr_tick_ready_low", cmd_ready, 0);
    check_eq("clr_tick_running", running, 1);
    step();
    check_eq("clr_tick_ready_high", cmd_ready, 1);
    check_eq("clr_tick_count2", count, 0);
    drain("clr_drain", 20);

    // Reset mid-run with a command held valid
    mon_en    = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 16'h1234;
    Resetn    = 1'b0;
    step();
    cmd_valid = 1'b0;
    Resetn    = 1'b1;
    check_eq("rst_mid_count", count, 0);
    check_eq("rst_mid_running", running, 0);
    check_eq("rst_mid_ready", cmd_ready, 1);
    check_eq("rst_mid_tc", tc_pulse, 0);
    repeat (3) step();
    check_eq("rst_mid_count_after", count, 0);
    check_eq("rst_mid_running_after", running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
